// File: rtl/stopwatch_bcd_core_if.sv
// Signal bundle for stopwatch_bcd_core.
// Optional macro: LAP_EN adds the raw 'lap' button input.
// Signalling: 'tick' is a one-cycle strobe with no backpressure; it is
// acted on only in RUN and dropped otherwise. Buttons are raw levels that
// the core synchronizes itself. Outputs are registered levels that are
// valid every cycle. No valid/ready pair exists on this block.
interface stopwatch_bcd_core_if;
  logic        tick;
  logic        start_stop;
  logic [1:0]  mode;
  logic [7:0]  ext_load;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef LAP_EN
  logic        lap;

  modport master (output tick, start_stop, lap, mode, ext_load,
                  input  digits, running, done, dbg_state);
  modport slave  (input  tick, start_stop, lap, mode, ext_load,
                  output digits, running, done, dbg_state);
`else
  modport master (output tick, start_stop, mode, ext_load,
                  input  digits, running, done, dbg_state);
  modport slave  (input  tick, start_stop, mode, ext_load,
                  output digits, running, done, dbg_state);
`endif
endinterface

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timekeeping core: 4-digit BCD count SS.hh, up/down with preset,
// start/stop button synchronized, debounced and edge-detected in here.
// Optional macro: LAP_EN adds a lap button that freezes the displayed value
// while the count keeps running.
// dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE).

// Button conditioner: 2-flop synchronizer, stability counter, rising-edge
// pulse. The accepted level follows the synchronized level only after it
// has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module stopwatch_bcd_core_db #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);
  logic            r_meta;
  logic            r_sync;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;

  // Synchronize, debounce and register the rising edge of the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_meta    <= i_raw;
      r_sync    <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;
endmodule

module stopwatch_bcd_core #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_bcd_core_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_count;
  logic [15:0] w_count_next;
  logic [15:0] r_disp;
  logic [15:0] w_disp_next;
  logic [1:0]  r_mode;
  logic        r_running;
  logic        r_done;
  logic        w_press;
  logic        w_up;
  logic        w_mode_chg;
  logic [15:0] w_preset;
  logic [15:0] w_step;
  logic        w_limit_hit;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  stopwatch_bcd_core_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_db_start (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (bus.start_stop),
    .o_press (w_press)
  );

  assign w_up       = ~bus.mode[1];
  assign w_mode_chg = (bus.mode != r_mode);
  assign w_step     = w_up ? bcd_inc(r_count) : bcd_dec(r_count);
  assign w_limit_hit = w_up ? (w_step == 16'h9999) : (w_step == 16'h0000);

  // Preset for the current mode, ext_load digits clamped to 9.
  always_comb begin
    w_preset = 16'h0000;
    case (bus.mode)
      2'b00:   w_preset = 16'h0000;
      2'b10:   w_preset = 16'h9999;
      default: w_preset = {clamp9(bus.ext_load[7:4]), clamp9(bus.ext_load[3:0]), 8'h00};
    endcase
  end

  // Next state and next count; a mode change beats press and tick.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (w_mode_chg) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            // Counting down from 00.00 has nothing to do.
            if (!w_up && (w_preset == 16'h0000)) w_state_next = ST_DONE;
            else                                 w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.tick) begin
            w_count_next = w_step;
            if (w_limit_hit)  w_state_next = ST_DONE;
            else if (w_press) w_state_next = ST_PAUSE;
          end else if (w_press) begin
            w_state_next = ST_PAUSE;
          end
        end
        ST_PAUSE: if (w_press) w_state_next = ST_RUN;
        ST_DONE:  if (w_press) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
    // IDLE tracks the preset continuously, and every entry to IDLE reloads it.
    if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE)) w_count_next = w_preset;
  end

`ifdef LAP_EN
  logic        w_lap_press;
  logic        r_lap_frozen;
  logic        w_lap_frozen_next;
  logic [15:0] r_lap_val;
  logic [15:0] w_lap_val_next;

  stopwatch_bcd_core_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_db_lap (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (bus.lap),
    .o_press (w_lap_press)
  );

  // Lap presses toggle the frozen view, only while running.
  always_comb begin
    w_lap_frozen_next = r_lap_frozen;
    w_lap_val_next    = r_lap_val;
    if (w_mode_chg || (w_state_next == ST_IDLE)) begin
      w_lap_frozen_next = 1'b0;
    end else if (w_lap_press && (r_state == ST_RUN)) begin
      if (r_lap_frozen) begin
        w_lap_frozen_next = 1'b0;
      end else begin
        w_lap_frozen_next = 1'b1;
        w_lap_val_next    = r_count;
      end
    end
    w_disp_next = w_lap_frozen_next ? w_lap_val_next : w_count_next;
  end

  // Lap register and frozen flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_frozen <= 1'b0;
      r_lap_val    <= 16'h0000;
    end else begin
      r_lap_frozen <= w_lap_frozen_next;
      r_lap_val    <= w_lap_val_next;
    end
  end
`else
  assign w_disp_next = w_count_next;
`endif

  // State, count and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= 16'h0000;
      r_disp    <= 16'h0000;
      r_mode    <= 2'b00;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_disp    <= w_disp_next;
      r_mode    <= bus.mode;
      r_running <= (w_state_next == ST_RUN);
      r_done    <= (w_state_next == ST_DONE);
    end
  end

  assign bus.digits    = r_disp;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core. Define LAP_EN to include the
// lap scenario. Inputs change on the falling edge; outputs are sampled there.
module tb_stopwatch_bcd_core;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  stopwatch_bcd_core_if sw_if ();

  stopwatch_bcd_core #(.DEBOUNCE_CYCLES(16), .DB_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks (all entered and left on a falling edge)
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      sw_if.tick = 1'b1;
      @(negedge clk);
      sw_if.tick = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic press_btn();
    sw_if.start_stop = 1'b1;
    wait_cyc(24);
    sw_if.start_stop = 1'b0;
    wait_cyc(24);
  endtask

`ifdef LAP_EN
  task automatic press_lap();
    sw_if.lap = 1'b1;
    wait_cyc(24);
    sw_if.lap = 1'b0;
    wait_cyc(24);
  endtask
`endif

  task automatic test_reset();
    n_checks++; if (sw_if.digits !== 16'h0000) begin n_errors++; $display("FAIL reset_digits got=%h exp=0000", sw_if.digits); end
    n_checks++; if (sw_if.running !== 1'b0) begin n_errors++; $display("FAIL reset_running got=%b exp=0", sw_if.running); end
    n_checks++; if (sw_if.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", sw_if.done); end
    reset = 1'b0;
    wait_cyc(2);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL idle_preset got=%h exp=%h", sw_if.digits, e); end
  endtask

  task automatic test_count_up();
    sw_if.mode = 2'b00;
    press_btn();
    n_checks++; if (sw_if.running !== 1'b1) begin n_errors++; $display("FAIL up_running got=%b exp=1", sw_if.running); end
    tick_n(150);
    exp_q.push_back(16'h0150);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL up_150 got=%h exp=%h", sw_if.digits, e); end
    press_btn();
    n_checks++; if (sw_if.running !== 1'b0) begin n_errors++; $display("FAIL pause_running got=%b exp=0", sw_if.running); end
    tick_n(10);
    exp_q.push_back(16'h0150);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL pause_frozen got=%h exp=%h", sw_if.digits, e); end
  endtask

  task automatic test_async_reset();
    #3 reset = 1'b1;
    #1;
    n_checks++; if (sw_if.digits !== 16'h0000) begin n_errors++; $display("FAIL areset_digits got=%h exp=0000", sw_if.digits); end
    n_checks++; if (sw_if.running !== 1'b0 || sw_if.done !== 1'b0) begin n_errors++; $display("FAIL areset_flags got=%b%b exp=00", sw_if.running, sw_if.done); end
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_count_down();
    sw_if.mode = 2'b11;
    sw_if.ext_load = 8'h01;
    wait_cyc(2);
    exp_q.push_back(16'h0100);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL down_preset got=%h exp=%h", sw_if.digits, e); end
    press_btn();
    tick_n(99);
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.done !== 1'b0) begin n_errors++; $display("FAIL down_99 got=%h done=%b exp=%h done=0", sw_if.digits, sw_if.done, e); end
    tick_n(1);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.done !== 1'b1 || sw_if.running !== 1'b0) begin n_errors++; $display("FAIL down_limit got=%h done=%b run=%b exp=%h done=1 run=0", sw_if.digits, sw_if.done, sw_if.running, e); end
    tick_n(5);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL down_hold got=%h exp=%h", sw_if.digits, e); end
    press_btn();
    exp_q.push_back(16'h0100);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.done !== 1'b0) begin n_errors++; $display("FAIL done_to_idle got=%h done=%b exp=%h done=0", sw_if.digits, sw_if.done, e); end
  endtask

  task automatic test_carry_limit();
    sw_if.mode = 2'b01;
    sw_if.ext_load = 8'h99;
    wait_cyc(2);
    exp_q.push_back(16'h9900);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL up_preset got=%h exp=%h", sw_if.digits, e); end
    press_btn();
    tick_n(98);
    exp_q.push_back(16'h9998);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.running !== 1'b1) begin n_errors++; $display("FAIL up_98 got=%h run=%b exp=%h run=1", sw_if.digits, sw_if.running, e); end
    tick_n(1);
    exp_q.push_back(16'h9999);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.done !== 1'b1) begin n_errors++; $display("FAIL up_limit got=%h done=%b exp=%h done=1", sw_if.digits, sw_if.done, e); end
    tick_n(3);
    exp_q.push_back(16'h9999);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL up_nowrap got=%h exp=%h", sw_if.digits, e); end
  endtask

  task automatic test_debounce();
    logic seen;
    int   lat;
    sw_if.mode = 2'b00;
    wait_cyc(2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_if.start_stop = ~sw_if.start_stop;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (sw_if.running || sw_if.done) seen = 1'b1;
      end
    end
    sw_if.start_stop = 1'b0;
    wait_cyc(5);
    n_checks++; if (seen !== 1'b0 || sw_if.dbg_state !== 2'd0) begin n_errors++; $display("FAIL bounce_ignored seen=%b state=%0d exp seen=0 state=0", seen, sw_if.dbg_state); end
    // Raw high -> press pulse after 19 edges, running registered one edge later.
    sw_if.start_stop = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sw_if.running && lat == 0) lat = i;
    end
    n_checks++; if (lat != 20) begin n_errors++; $display("FAIL press_latency got=%0d exp=20 (0 means never)", lat); end
    sw_if.start_stop = 1'b0;
    wait_cyc(24);
    n_checks++; if (sw_if.running !== 1'b1) begin n_errors++; $display("FAIL single_press got=%b exp=1", sw_if.running); end
  endtask

  task automatic test_corners();
    tick_n(5);
    exp_q.push_back(16'h0005);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL run_5 got=%h exp=%h", sw_if.digits, e); end
    sw_if.mode = 2'b10;
    @(negedge clk);
    exp_q.push_back(16'h9999);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.running !== 1'b0) begin n_errors++; $display("FAIL mode_chg got=%h run=%b exp=%h run=0", sw_if.digits, sw_if.running, e); end
    sw_if.mode = 2'b01;
    sw_if.ext_load = 8'hA3;
    @(negedge clk);
    exp_q.push_back(16'h9300);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL clamp got=%h exp=%h", sw_if.digits, e); end
    sw_if.ext_load = 8'h27;
    @(negedge clk);
    exp_q.push_back(16'h2700);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL idle_load got=%h exp=%h", sw_if.digits, e); end
    press_btn();
    sw_if.ext_load = 8'h55;
    tick_n(1);
    exp_q.push_back(16'h2701);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL run_load_ignored got=%h exp=%h", sw_if.digits, e); end
    // Press and tick land on the same edge: tick applies, then PAUSE.
    sw_if.start_stop = 1'b1;
    wait_cyc(19);
    sw_if.tick = 1'b1;
    @(negedge clk);
    sw_if.tick = 1'b0;
    exp_q.push_back(16'h2702);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.dbg_state !== 2'd2) begin n_errors++; $display("FAIL press_tick got=%h state=%0d exp=%h state=2", sw_if.digits, sw_if.dbg_state, e); end
    wait_cyc(4);
    sw_if.start_stop = 1'b0;
    wait_cyc(24);
    sw_if.mode = 2'b11;
    sw_if.ext_load = 8'h00;
    wait_cyc(2);
    press_btn();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e || sw_if.done !== 1'b1 || sw_if.running !== 1'b0) begin n_errors++; $display("FAIL down_zero got=%h done=%b run=%b exp=%h done=1 run=0", sw_if.digits, sw_if.done, sw_if.running, e); end
  endtask

`ifdef LAP_EN
  task automatic test_lap();
    sw_if.mode = 2'b00;
    wait_cyc(2);
    press_btn();
    tick_n(42);
    press_lap();
    tick_n(50);
    exp_q.push_back(16'h0042);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL lap_frozen got=%h exp=%h", sw_if.digits, e); end
    press_lap();
    exp_q.push_back(16'h0092);
    e = exp_q.pop_front();
    n_checks++; if (sw_if.digits !== e) begin n_errors++; $display("FAIL lap_release got=%h exp=%h", sw_if.digits, e); end
  endtask
`endif

  // Sequence and report
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    sw_if.tick = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.mode = 2'b00;
    sw_if.ext_load = 8'h00;
`ifdef LAP_EN
    sw_if.lap = 1'b0;
`endif
    wait_cyc(3);
    test_reset();
    test_count_up();
    test_async_reset();
    test_count_down();
    test_carry_limit();
    test_debounce();
    test_corners();
`ifdef LAP_EN
    test_lap();
`endif
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
